// File: rtl/shift_reg_seq_if.sv
// Bundle for the serializer: parallel-word handshake on one side, serial bit stream on the other.
interface shift_reg_seq_if #(parameter int N = 4);
  logic [N-1:0] Data;
  logic         in_valid;
  logic         in_ready;
  logic         dir;
  logic         abort;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic [N-1:0] Q;
  logic         busy;
  logic         done;

  modport master (
    output Data, in_valid, dir, abort, sout_ready,
    input  in_ready, sout, sout_valid, Q, busy, done
  );

  modport slave (
    input  Data, in_valid, dir, abort, sout_ready,
    output in_ready, sout, sout_valid, Q, busy, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Parallel-load shift register plus bit counter and FSM that streams one word out serially,
// MSB- or LSB-first, with backpressure, abort and a one-cycle done pulse.
module shift_reg_seq #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input logic            clk,
  input logic            rst,
  shift_reg_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          dir_q;
  logic          in_ready_q;
  logic          sout_valid_q;
  logic          busy_q;
  logic          done_q;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      dir_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      // Cancel wins over a simultaneous final shift, so no done pulse escapes.
      state        <= IDLE;
      sreg         <= '0;
      cnt          <= '0;
      in_ready_q   <= 1'b1;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state        <= SHIFT;
            sreg         <= bus.Data;
            dir_q        <= bus.dir;
            cnt          <= '0;
            in_ready_q   <= 1'b0;
            sout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.sout_ready) begin
            sreg <= dir_q ? {1'b0, sreg[N-1:1]} : {sreg[N-2:0], 1'b0};
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
              state        <= DONE;
              sout_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          in_ready_q   <= 1'b1;
          sout_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  // Output bit comes straight off the register so it is stable for the whole cycle.
  assign bus.sout       = sout_valid_q & (dir_q ? sreg[0] : sreg[N-1]);
  assign bus.sout_valid = sout_valid_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.Q          = sreg;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: inputs change and outputs are sampled on the falling edge.
module tb_shift_reg_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  shift_reg_seq_if #(.N(N)) bus ();
  shift_reg_seq #(.N(N), .CW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one word, then check the N presented bits (seq[N-1] first), done and return to idle.
  // Data and dir are scrambled during the transfer; they must have no effect.
  task automatic send_word(input string tag, input logic [3:0] d, input logic dr, input logic [3:0] seq);
    bus.Data = d; bus.dir = dr; bus.in_valid = 1'b1; bus.sout_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk({tag, "_vld"}, 8'(bus.sout_valid), 8'd1);
      chk({tag, "_bit"}, 8'(bus.sout), 8'(seq[N-1-i]));
      bus.dir  = ~bus.dir;
      bus.Data = ~bus.Data;
      step();
    end
    chk({tag, "_done"}, 8'(bus.done), 8'd1);
    chk({tag, "_q0"}, 8'(bus.Q), 8'h0);
    chk({tag, "_rdy_lo"}, 8'(bus.in_ready), 8'd0);
    step();
    chk({tag, "_done_clr"}, 8'(bus.done), 8'd0);
    chk({tag, "_rdy_hi"}, 8'(bus.in_ready), 8'd1);
  endtask

  initial begin
    int lowcnt;
    rst = 1'b1; bus.in_valid = 1'b1; bus.Data = 4'b1111; bus.dir = 1'b0;
    bus.abort = 1'b0; bus.sout_ready = 1'b1;
    step(); step();
    chk("rst_q", 8'(bus.Q), 8'h0);
    chk("rst_rdy", 8'(bus.in_ready), 8'd1);
    chk("rst_svld", 8'(bus.sout_valid), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    rst = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("idle_noacc", 8'(bus.busy), 8'd0);

    send_word("msb", 4'b0110, 1'b0, 4'b0110);
    send_word("lsb", 4'b0111, 1'b1, 4'b1110);

    // Backpressure: stall 3 cycles once two bits (1,0) of 1010 are taken.
    bus.Data = 4'b1010; bus.dir = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("bp_b0", 8'(bus.sout), 8'd1); step();
    chk("bp_b1", 8'(bus.sout), 8'd0); step();
    bus.sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_bit", 8'(bus.sout), 8'd1);
      chk("bp_hold_q", 8'(bus.Q), 8'b1000);
      chk("bp_hold_vld", 8'(bus.sout_valid), 8'd1);
      step();
    end
    bus.sout_ready = 1'b1;
    chk("bp_b2", 8'(bus.sout), 8'd1); step();
    chk("bp_b3", 8'(bus.sout), 8'd0); step();
    chk("bp_done", 8'(bus.done), 8'd1);
    step();

    // Abort after two bits of 1100.
    bus.Data = 4'b1100; bus.dir = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("ab_b0", 8'(bus.sout), 8'd1); step();
    chk("ab_b1", 8'(bus.sout), 8'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_rdy", 8'(bus.in_ready), 8'd1);
    chk("ab_q", 8'(bus.Q), 8'h0);
    chk("ab_busy", 8'(bus.busy), 8'd0);
    chk("ab_svld", 8'(bus.sout_valid), 8'd0);
    chk("ab_done", 8'(bus.done), 8'd0);
    step();
    chk("ab_done2", 8'(bus.done), 8'd0);
    send_word("after_ab", 4'b0011, 1'b0, 4'b0011);

    // Abort coincident with the final shift: no done.
    bus.Data = 4'b1111; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ablast_done", 8'(bus.done), 8'd0);
    chk("ablast_rdy", 8'(bus.in_ready), 8'd1);

    // Abort in IDLE is ignored; the word is accepted.
    bus.Data = 4'b0101; bus.in_valid = 1'b1; bus.abort = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.abort = 1'b0;
    chk("abidle_busy", 8'(bus.busy), 8'd1);
    chk("abidle_q", 8'(bus.Q), 8'b0101);
    // Reset mid-transfer discards the word.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_q", 8'(bus.Q), 8'h0);
    chk("rstmid_rdy", 8'(bus.in_ready), 8'd1);
    chk("rstmid_svld", 8'(bus.sout_valid), 8'd0);
    chk("rstmid_sout", 8'(bus.sout), 8'd0);

    // Back-to-back with in_valid held high.
    bus.Data = 4'b0110; bus.dir = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.Data = 4'b1001;
    lowcnt = 0;
    for (int i = 0; i < N; i++) begin
      chk("b2b_w0_bit", 8'(bus.sout), 8'(i == 1 || i == 2));
      if (!bus.in_ready) lowcnt++;
      step();
    end
    chk("b2b_w0_done", 8'(bus.done), 8'd1);
    if (!bus.in_ready) lowcnt++;
    step();
    chk("b2b_rdy", 8'(bus.in_ready), 8'd1);
    chk("b2b_lowwin", 8'(lowcnt), 8'd5);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("b2b_w1_bit", 8'(bus.sout), 8'(i == 0 || i == 3));
      step();
    end
    chk("b2b_w1_done", 8'(bus.done), 8'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
